// File: rtl/bias_stream_adder.sv
// bias_stream_adder
//
// Per-channel bias stage for the convolution datapath. One sign-magnitude
// bias word per output channel is held in a small memory that is loaded
// serially at run time. Accumulator beats are consumed channel by channel,
// the matching bias is added at ACC_W+1 bits, optional ReLU is applied and
// the result is saturated to OUT_W bits on a registered valid/ready output.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   load_valid    bias word present on load_data (LOAD state only)
//   load_data     sign-magnitude bias, written at consecutive addresses from 0
//   reload        single-cycle request to restart loading
//   bias_ready    high while in RUN (doubles as the state observation point)
//   relu_en       clamp negative results to zero, sampled with each beat
//   in_valid/in_ready/in_data      accumulator input stream
//   out_valid/out_ready/out_data   biased, saturated result stream
//   out_ch        channel index of out_data
//   out_last      high when out_ch is the last channel
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A source never drops valid or changes data while valid is high
// and ready is low; ready may depend combinationally on the sink's ready.

module bias_stream_adder #(
   parameter  int CHANNELS = 64,
   parameter  int BIAS_W   = 16,
   parameter  int ACC_W    = 32,
   parameter  int OUT_W    = 16,
   localparam int CH_W     = $clog2(CHANNELS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [BIAS_W-1:0] load_data,
   input  logic              reload,
   output logic              bias_ready,
   input  logic              relu_en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ACC_W-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic [CH_W-1:0]   out_ch,
   output logic              out_last
);

   localparam logic [CH_W-1:0] LAST_IDX = CH_W'(CHANNELS - 1);

   // Saturation bounds expressed at the internal ACC_W+1 sum width.
   localparam logic signed [ACC_W:0] SAT_MAX =
      {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN =
      {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [CH_W-1:0]   wr_ptr_q;
   logic [CH_W-1:0]   ch_q;
   logic [BIAS_W-1:0] mem [CHANNELS];

   logic                    in_hs;
   logic                    load_wr;
   logic [BIAS_W-1:0]       bias_word;
   logic signed [ACC_W:0]   bias_mag;
   logic signed [ACC_W:0]   bias_ext;
   logic signed [ACC_W:0]   sum;
   logic signed [ACC_W:0]   relu_sum;
   logic [OUT_W-1:0]        sat_data;

   // ---------------------------------------------------------------
   // State register and next-state logic
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: begin
            // reload takes priority over a coincident load write
            if (!reload && load_valid && (wr_ptr_q == LAST_IDX)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (reload) begin
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   assign bias_ready = (state_q == ST_RUN);
   assign in_ready   = bias_ready && (!out_valid || out_ready);
   assign in_hs      = in_valid && in_ready;
   assign load_wr    = (state_q == ST_LOAD) && load_valid && !reload;

   // ---------------------------------------------------------------
   // Write pointer and channel counter
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         ch_q     <= '0;
      end else if (reload) begin
         // A beat accepted in this cycle still used the old ch_q / bias.
         wr_ptr_q <= '0;
         ch_q     <= '0;
      end else begin
         if (load_wr) begin
            wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
         end
         if (in_hs) begin
            ch_q <= (ch_q == LAST_IDX) ? '0 : ch_q + 1'b1;
         end
      end
   end

   // Bias memory: contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (!rst && load_wr) begin
         mem[wr_ptr_q] <= load_data;
      end
   end

   // ---------------------------------------------------------------
   // Datapath: sign-magnitude to two's complement, add, ReLU, saturate
   // ---------------------------------------------------------------
   always_comb begin
      bias_word = mem[ch_q];
      bias_mag  = {{(ACC_W + 2 - BIAS_W){1'b0}}, bias_word[BIAS_W-2:0]};
      // Negating a zero magnitude yields zero, so -0 folds to +0 naturally.
      bias_ext  = bias_word[BIAS_W-1] ? -bias_mag : bias_mag;
      sum       = $signed({in_data[ACC_W-1], in_data}) + bias_ext;
      relu_sum  = (relu_en && sum[ACC_W]) ? '0 : sum;
      sat_data  = relu_sum[OUT_W-1:0];
      if (relu_sum > SAT_MAX) begin
         sat_data = SAT_MAX[OUT_W-1:0];
      end else if (relu_sum < SAT_MIN) begin
         sat_data = SAT_MIN[OUT_W-1:0];
      end
   end

   // ---------------------------------------------------------------
   // Output register: loads on an input handshake, otherwise holds
   // until the downstream accepts.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
      end else if (in_hs) begin
         out_valid <= 1'b1;
         out_data  <= sat_data;
         out_ch    <= ch_q;
         out_last  <= (ch_q == LAST_IDX);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/bias_stream_adder.md
# bias_stream_adder

Loadable, parametrised per-channel bias stage for the fire-module convolution datapath. It holds one sign-magnitude bias word per output channel in an internal memory, loaded serially at run time rather than fixed at synthesis. It consumes the accumulator stream channel by channel, adds the matching bias, and applies optional ReLU. It then saturates and presents the result on a valid/ready output towards the next layer.

## Interface
- CHANNELS, 64, number of output channels / bias entries (≥2)
- BIAS_W, 16, bias word width; bit BIAS_W-1 = sign, bits BIAS_W-2:0 = magnitude
- ACC_W, 32, accumulator input width, two's complement (ACC_W ≥ BIAS_W)
- OUT_W, 16, output width, two's complement (OUT_W ≤ ACC_W)

Ports, as name / direction / width / meaning:
- clk  in  1  the single clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  bias word present on load_data
- load_data  in  BIAS_W  sign-magnitude bias, written at consecutive addresses from 0
- reload  in  1  single-cycle request to re-enter LOAD
- bias_ready  out  1  high in RUN (all CHANNELS words loaded)
- relu_en  in  1  clamp negative results to 0; sampled with each input beat
- in_valid  in  1  accumulator beat valid
- in_ready  out  1  block accepts the beat
- in_data  in  ACC_W  signed accumulator value
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  OUT_W  biased, saturated result
- out_ch  out  clog2(CHANNELS)  channel index of out_data
- out_last  out  1  out_ch == CHANNELS-1

## Operation
- There are two states, LOAD and RUN. Reset enters LOAD with wr_ptr=0 and ch=0.
- Reset values: out_valid=0, out_data=0, out_ch=0, out_last=0, bias_ready=0, in_ready=0.
- Memory contents are not reset; they are undefined until loaded.
- LOAD:
  - in_ready=0.
  - Each cycle with load_valid writes mem[wr_ptr] and increments wr_ptr.
  - The write at wr_ptr==CHANNELS-1 moves the block to RUN on the next cycle and wraps wr_ptr to 0.
  - load_valid in RUN is ignored.
- RUN:
  - bias_ready=1.
  - in_ready = !out_valid || out_ready, so there is no bubble under continuous flow.
  - Each input handshake uses bias mem[ch]; ch increments and wraps from CHANNELS-1 to 0.
- Bias conversion:
  - b = sign ? -mag : +mag, sign-extended to ACC_W+1 bits.
  - Negative zero (sign=1, mag=0) equals +0.
- Sum: s = sext(in_data, ACC_W+1) + b, computed at ACC_W+1 bits so it never overflows internally.
- ReLU: if relu_en and s<0, then s=0.
- Saturation to OUT_W:
  - s > 2^(OUT_W-1)-1 gives the maximum.
  - s < -2^(OUT_W-1) gives the minimum.
  - Otherwise the low OUT_W bits.
- reload in RUN:
  - Next cycle: state=LOAD, ch=0, wr_ptr=0, bias_ready=0, in_ready=0.
  - A pending output stays valid and is held until out_ready.
  - A beat that handshakes in the same cycle as reload is processed with the old bias.
- reload in LOAD restarts loading at wr_ptr=0.
- rst mid-operation: the next cycle matches the reset values; a pending output is dropped.

## Timing
- Latency is 1 cycle: an input handshake at edge N gives out_valid with its result after edge N.
- Throughput is 1 beat/cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, out_data, out_ch and out_last are stable and in_ready=0.
- Full load takes exactly CHANNELS load_valid cycles; bias_ready rises the cycle after the last write.
- in_ready is registered-state based: a function of state and out_valid, plus combinational out_ready.

## Test plan
- Load CHANNELS=4 with biases 0x8001, 0x0028, 0x8000, 0x00EF, then stream in_data 100,100,100,100 with relu_en=0 → out_data 99,140,100,339; out_ch 0..3; out_last only on the 4th beat; bias_ready rises 1 cycle after the 4th load.
- OUT_W=16, bias 0x0005, in_data 32767 → 32767; bias 0x8005, in_data -32768 → -32768 (saturation both ways).
- relu_en=1, bias 0x0003, in_data -10 → 0; in_data 10 → 13.
- Stream 10 beats with out_ready toggling 1,0,0,1,… → no beat lost or duplicated, output held stable while stalled, channel sequence wraps 0,1,2,3,0,…
- reload pulsed with an output pending and out_ready=0 → output retained until accepted; in_ready=0; a new load of 4 words takes effect; the first new beat uses ch=0.
- rst asserted mid-stream and mid-load → out_valid=0 and bias_ready=0 next cycle; a fresh 4-word load restores RUN with ch=0.
